// File: rtl/synch_filter.sv
// rtl/synch_filter.sv - multi-channel input synchronizer with glitch filter and edge pulses
// Each channel: STAGES-deep sync chain, saturating persistence counter, registered level and edge pulses.
module synch_filter #(
    parameter int              WIDTH   = 3,
    parameter int              STAGES  = 2,
    parameter int              FILT    = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] A,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
);

    localparam logic [3:0] CNT_MAX = 4'(FILT - 1);

    logic [WIDTH-1:0]      syncQ [STAGES];
    logic [WIDTH-1:0]      syncS;
    logic [WIDTH-1:0][3:0] cntQ;
    logic [WIDTH-1:0][3:0] cntNext;
    logic [WIDTH-1:0]      yQ;
    logic [WIDTH-1:0]      yNext;
    logic [WIDTH-1:0]      riseQ;
    logic [WIDTH-1:0]      riseNext;
    logic [WIDTH-1:0]      fallQ;
    logic [WIDTH-1:0]      fallNext;

    // The chain keeps sampling regardless of en so the filter sees fresh data on resume.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                syncQ[k] <= RST_VAL;
            end
        end else begin
            syncQ[0] <= A;
            for (int k = 1; k < STAGES; k++) begin
                syncQ[k] <= syncQ[k-1];
            end
        end
    end

    assign syncS = syncQ[STAGES-1];

    // A channel's level is accepted only after FILT consecutive disagreeing samples.
    always_comb begin
        cntNext  = cntQ;
        yNext    = yQ;
        riseNext = '0;
        fallNext = '0;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (syncS[i] == yQ[i]) begin
                    cntNext[i] = 4'd0;
                end else if (cntQ[i] < CNT_MAX) begin
                    cntNext[i] = cntQ[i] + 4'd1;
                end else begin
                    cntNext[i]  = 4'd0;
                    yNext[i]    = syncS[i];
                    riseNext[i] = syncS[i];
                    fallNext[i] = ~syncS[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cntQ  <= '0;
            yQ    <= RST_VAL;
            riseQ <= '0;
            fallQ <= '0;
        end else begin
            cntQ  <= cntNext;
            yQ    <= yNext;
            riseQ <= riseNext;
            fallQ <= fallNext;
        end
    end

    assign Y    = yQ;
    assign rise = riseQ;
    assign fall = fallQ;
    assign chg  = |{riseQ, fallQ};

endmodule

// File: tb/tb_synch_filter.sv
// tb/tb_synch_filter.sv - directed self-checking bench for synch_filter
module tb_synch_filter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [2:0] A;
    logic [2:0] Y;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       chg;

    int total = 0;
    int bad   = 0;

    synch_filter #(
        .WIDTH  (3),
        .STAGES (2),
        .FILT   (4),
        .RST_VAL(3'b000)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .A   (A),
        .en  (en),
        .Y   (Y),
        .rise(rise),
        .fall(fall),
        .chg (chg)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply newA and walk 7 edges: Y must hold for 5, switch on edge 6 with pulses, pulses clear on edge 7.
    task automatic runStep(input string tag, input logic [2:0] newA, input logic [2:0] yOld,
                           input logic [2:0] yNew, input logic [2:0] expRise, input logic [2:0] expFall);
        A = newA;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6) begin
                checkVal({tag, "_hold"}, Y, yOld);
                checkVal({tag, "_nochg"}, {2'b00, chg}, 3'b000);
            end else if (e == 6) begin
                checkVal({tag, "_y"}, Y, yNew);
                checkVal({tag, "_rise"}, rise, expRise);
                checkVal({tag, "_fall"}, fall, expFall);
                checkVal({tag, "_chg"}, {2'b00, chg}, 3'b001);
            end else begin
                checkVal({tag, "_y_after"}, Y, yNew);
                checkVal({tag, "_pulse_clr"}, rise | fall, 3'b000);
                checkVal({tag, "_chg_clr"}, {2'b00, chg}, 3'b000);
            end
        end
    endtask

    initial begin
        int chgCount;
        rstn = 1'b0;
        en   = 1'b1;
        A    = 3'b111;

        // Reset held two cycles with all inputs high
        for (int c = 0; c < 2; c++) begin
            tick();
            checkVal("rst_y", Y, 3'b000);
            checkVal("rst_rise", rise, 3'b000);
            checkVal("rst_fall", fall, 3'b000);
            checkVal("rst_chg", {2'b00, chg}, 3'b000);
        end
        rstn = 1'b1;
        runStep("post_rst", 3'b111, 3'b000, 3'b111, 3'b111, 3'b000);

        // Channels 0 and 2 fall together, then channel 1 falls alone
        runStep("to_010", 3'b010, 3'b111, 3'b010, 3'b000, 3'b101);
        repeat (3) tick();
        runStep("ch1_fall", 3'b000, 3'b010, 3'b000, 3'b000, 3'b010);

        // Three-cycle glitch on channel 0 is rejected
        A = 3'b001;
        repeat (3) tick();
        A = 3'b000;
        for (int c = 0; c < 10; c++) begin
            tick();
            checkVal("glitch_y", Y, 3'b000);
            checkVal("glitch_rise", rise, 3'b000);
        end
        // Counter must have returned to zero: a real step still needs the full latency
        runStep("after_glitch", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        runStep("ch0_back", 3'b000, 3'b001, 3'b000, 3'b000, 3'b001);

        // Enable dropped mid-count on channel 2
        A = 3'b100;
        repeat (4) tick();
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkVal("en_off_y", Y, 3'b000);
            checkVal("en_off_rise", rise, 3'b000);
        end
        en = 1'b1;
        tick();
        checkVal("en_on_1_y", Y, 3'b000);
        tick();
        checkVal("en_on_2_y", Y, 3'b100);
        checkVal("en_on_2_rise", rise, 3'b100);
        tick();
        checkVal("en_on_3_rise", rise, 3'b000);
        runStep("ch2_back", 3'b000, 3'b100, 3'b000, 3'b000, 3'b100);

        // Reset in the middle of a count on channel 0
        A = 3'b001;
        repeat (5) tick();
        checkVal("midrst_pre_y", Y, 3'b000);
        rstn = 1'b0;
        tick();
        checkVal("midrst_y", Y, 3'b000);
        checkVal("midrst_pulse", rise | fall, 3'b000);
        rstn = 1'b1;
        runStep("midrst_after", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        runStep("ch0_clear", 3'b000, 3'b001, 3'b000, 3'b000, 3'b001);

        // All channels rise together, chg high exactly once
        A = 3'b111;
        chgCount = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (chg) chgCount++;
            if (e == 6) checkVal("all_rise", rise, 3'b111);
        end
        checkVal("all_rise_chg_once", 3'(chgCount), 3'd1);
        checkVal("all_rise_y", Y, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/synch_filter.md
SYNCH_FILTER -- requirements
Module: synch_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 3: number of independent channels; legal range 1 to 16.
REQ-002 SHALL have parameter STAGES, default 2: synchronizer flop depth per channel; legal range 2 to 4.
REQ-003 SHALL have parameter FILT, default 4: consecutive synchronized cycles required before a level change is accepted; legal range 1 to 15, where 1 means no filtering.
REQ-004 SHALL have parameter RST_VAL, default all-zero, WIDTH bits: value loaded into synchronizer stages and Y on reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port A, input, WIDTH bits: asynchronous raw channel inputs, e.g. JTAG TCK/TDI/TMS pins.
REQ-008 SHALL have port en, input, 1 bit: filter enable; when low, filter state and Y freeze.
REQ-009 SHALL have port Y, output, WIDTH bits: registered filtered level per channel.
REQ-010 SHALL have port rise, output, WIDTH bits: one-cycle pulse when Y[i] goes 0 to 1.
REQ-011 SHALL have port fall, output, WIDTH bits: one-cycle pulse when Y[i] goes 1 to 0.
REQ-012 SHALL have port chg, output, 1 bit: OR of all rise and fall bits, same cycle.

Function
REQ-013 SHALL implement, per channel, a STAGES-deep flop chain sampling A[i]; the last stage, S[i], is the only value used downstream.
REQ-014 SHALL keep, per channel, a counter CNT[i] of 4 bits that saturates at FILT-1.
REQ-015 SHALL, when en=1 and S[i]==Y[i], clear CNT[i] to 0 at the next edge.
REQ-016 SHALL, when en=1, S[i]!=Y[i] and CNT[i]<FILT-1, increment CNT[i] at the next edge.
REQ-017 SHALL, when en=1, S[i]!=Y[i] and CNT[i]==FILT-1, set Y[i]=S[i] and clear CNT[i] at the next edge.
REQ-018 SHALL, when en=0, hold CNT[i] and Y[i]; the synchronizer chain keeps sampling; rise, fall and chg are 0.
REQ-019 SHALL give a latency, for a held step on A[i] first captured at edge 1, of Y[i] changing at edge STAGES+FILT with en held high.
REQ-020 SHALL reject any S[i] deviation lasting fewer than FILT consecutive cycles; CNT[i] returns to 0 and Y[i] is unchanged.
REQ-021 SHALL register rise[i] and fall[i] in the same edge that updates Y[i], so each is high exactly one cycle, coincident with the first cycle of the new Y[i].
REQ-022 SHALL allow simultaneous changes on multiple channels; each channel has independent counters and pulses.
REQ-023 SHALL, with FILT=1, allow rise[i] and fall[i] on consecutive cycles, but never in the same cycle.
REQ-024 SHALL, with FILT>=2, keep successive pulses on one channel at least FILT cycles apart.

Reset
REQ-025 SHALL, on any edge with rstn=0, load all synchronizer stages and Y with RST_VAL, clear every CNT, and drive rise, fall and chg to 0.
REQ-026 SHALL discard any in-progress count on reset mid-operation; the reset itself generates no edge pulse.
REQ-027 SHALL, after rstn rises with A!=RST_VAL, treat each differing channel as a normal step: Y updates after STAGES+FILT edges with the matching rise or fall pulse.

Verification (WIDTH=3, STAGES=2, FILT=4, RST_VAL=000, en=1 unless stated)
REQ-028 SHALL cover: rstn=0 for 2 cycles with A=111 -> Y=000, rise=fall=000 during reset; Y=111 at the 6th edge after release, rise=111 and chg=1 for that one cycle.
REQ-029 SHALL cover: A[0] pulsed high for 3 cycles -> Y[0] stays 0, rise[0] never asserts, CNT[0] returns to 0.
REQ-030 SHALL cover: A=010 stable, then A[1] 1 to 0 held -> Y[1]=0 exactly 6 edges after capture, fall[1]=1 and chg=1 for one cycle, then fall=000.
REQ-031 SHALL cover: A[2] step 0 to 1, en dropped after CNT[2]=2 for 5 cycles, then raised -> Y[2] holds 0 while en=0, then becomes 1 two edges after en returns high.
REQ-032 SHALL cover: A[0] step, rstn=0 for one cycle at CNT[0]=3 -> Y=000, CNT=0, no pulse; after release, A still 1 -> Y[0]=1 6 edges later.
REQ-033 SHALL cover: A 000 to 111 simultaneously -> rise=111 in one cycle, chg=1 once.
